// File: rtl/glip_loopback_pkg.sv
// Shared mode and state encodings for the GLIP loopback/generator endpoint.
package glip_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP  = 2'd0,
    MODE_GEN   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_IDLE  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/glip_fifo_sync.sv
// Synchronous ready/valid FIFO with occupancy output and a synchronous flush.
// A word written on one edge is visible at the output only after that edge,
// so there is never a same-cycle fall-through, and a full FIFO never accepts
// a write even while it is being read.
module glip_fifo_sync
  import glip_loopback_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      fill
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             push, pop;

  assign in_ready  = (fill_q != FULL_CNT);
  assign out_valid = (fill_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fill      = fill_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy update; flush overrides any transfer this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      fill_d = fill_q + (AW + 1)'(1);
      else if (!push && pop) fill_d = fill_q - (AW + 1)'(1);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/glip_loopback_gen.sv
// GLIP host-link traffic endpoint: buffered loopback, incrementing-pattern
// generator and pattern checker, with transfer and error counters.
module glip_loopback_gen
  import glip_loopback_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 21,
  parameter int ERR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_WIDTH-1:0]   xfer_count,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic                   err_flag,
  output logic [$clog2(DEPTH):0] fill
);

  mode_e                mode_q, mode_d;
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     val_q, val_d;     // generator value in GEN, expected word in CHECK
  logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 flag_q, flag_d;

  logic             run, mode_chg, is_loop;
  logic             in_xfer, out_xfer;
  logic             fifo_in_ready, fifo_out_valid;
  logic [WIDTH-1:0] fifo_out_data;

  assign run      = rst_n && (state_q == ST_RUN);
  assign mode_chg = run && (mode_e'(mode) != mode_q);
  assign is_loop  = run && (mode_q == MODE_LOOP);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  glip_fifo_sync #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (mode_chg),
    .in_data  (in_data),
    .in_valid (in_valid && is_loop),
    .in_ready (fifo_in_ready),
    .out_data (fifo_out_data),
    .out_valid(fifo_out_valid),
    .out_ready(out_ready && is_loop),
    .fill     (fill)
  );

  // Handshake and data muxing by active mode; both handshakes idle outside RUN.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (mode_q)
      MODE_LOOP: begin
        in_ready  = fifo_in_ready;
        out_valid = fifo_out_valid;
        out_data  = fifo_out_data;
      end
      MODE_GEN: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        out_data  = val_q;
      end
      MODE_CHECK: in_ready = 1'b1;
      default: ;
    endcase
    in_ready  = in_ready && run;
    out_valid = out_valid && run;
  end

  // Mode/state sequencing and counter updates; a mode change clears everything
  // after letting this edge's transfers complete under the old mode.
  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    val_d   = val_q;
    xfer_d  = xfer_q;
    err_d   = err_q;
    flag_d  = flag_q;
    if (state_q == ST_FLUSH) begin
      state_d = ST_RUN;
    end else begin
      case (mode_q)
        MODE_LOOP: if (out_xfer) xfer_d = xfer_q + CNT_WIDTH'(1);
        MODE_GEN: begin
          if (out_xfer) begin
            val_d  = val_q + WIDTH'(1);
            xfer_d = xfer_q + CNT_WIDTH'(1);
          end
        end
        MODE_CHECK: begin
          if (in_xfer) begin
            xfer_d = xfer_q + CNT_WIDTH'(1);
            val_d  = in_data + WIDTH'(1);
            if (in_data != val_q) begin
              flag_d = 1'b1;
              if (err_q != {ERR_WIDTH{1'b1}}) err_d = err_q + ERR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
      if (mode_chg) begin
        mode_d  = mode_e'(mode);
        state_d = ST_FLUSH;
        val_d   = '0;
        xfer_d  = '0;
        err_d   = '0;
        flag_d  = 1'b0;
      end
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      state_q <= ST_FLUSH;
      val_q   <= '0;
      xfer_q  <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      val_q   <= val_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  assign xfer_count = xfer_q;
  assign err_count  = err_q;
  assign err_flag   = flag_q;

endmodule

// File: doc/glip_loopback_gen.md
# glip_loopback_gen

Parametrised traffic endpoint for the GLIP host link. It sits between a GLIP backend's FIFO interface and the user logic, and replaces the fixed 16-bit wire loopback. It offers buffered loopback, an incrementing-pattern generator and a pattern checker, selectable at run time, with transfer and error counters for LEDs or debug registers.

## Interface
Parameters:
- WIDTH, 16, data word width (1..64)
- DEPTH, 16, loopback buffer depth in words (power of two, >= 2)
- CNT_WIDTH, 21, width of xfer_count
- ERR_WIDTH, 16, width of err_count

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- mode  in  2  0 LOOP, 1 GEN, 2 CHECK, 3 IDLE
- in_data  in  WIDTH  word from host (backend fifo_out_data)
- in_valid  in  1  host word valid
- in_ready  out  1  block accepts host word
- out_data  out  WIDTH  word to host (backend fifo_in_data)
- out_valid  out  1  word to host valid
- out_ready  in  1  backend accepts word
- xfer_count  out  CNT_WIDTH  completed transfers in current mode, wraps
- err_count  out  ERR_WIDTH  CHECK mismatches, saturates at all-ones
- err_flag  out  1  sticky, set on first mismatch
- fill  out  $clog2(DEPTH)+1  loopback buffer occupancy

## Operation
- Handshake: a transfer occurs on a posedge with valid & ready both high. The source holds data and valid until accepted. valid never depends on ready.
- mode_q is a registered copy of mode; all behaviour follows mode_q.
- Mode change: on an edge where mode != mode_q, the block does all of the following:
  - loads mode_q
  - empties the buffer
  - clears xfer_count, err_count, err_flag, the generator value and the expected value to 0
  - enters a FLUSH cycle in which in_ready = out_valid = 0
- Transfers in the edge that detects the change complete under the old mode and are then discarded by the clear.
- States: RUN and FLUSH. RUN goes to FLUSH on a mode change. FLUSH goes to RUN unconditionally after one cycle.
- LOOP:
  - Host words are written into the buffer and read out unchanged, in order.
  - in_ready = !full; out_valid = !empty.
  - xfer_count increments per output transfer.
- GEN:
  - out_valid = 1 and out_data = gen value.
  - gen increments by 1 per output transfer, modulo 2^WIDTH.
  - in_ready = 1; input words are discarded.
  - xfer_count counts output transfers.
- CHECK:
  - in_ready = 1, out_valid = 0.
  - Each input transfer is compared with exp:
    - match: exp <= in_data+1.
    - mismatch: err_count increments (saturating), err_flag <= 1, and exp <= in_data+1 (resynchronise).
  - xfer_count counts input transfers.
- IDLE: in_ready = out_valid = 0. Counters hold.
- All arithmetic is unsigned and modulo its register width. err_count alone saturates.

## Timing
- Reset (rst_n low at posedge):
  - mode_q <= IDLE, state <= FLUSH.
  - Buffer empty, all counters and err_flag = 0, out_data = 0.
  - in_ready = out_valid = 0 during and for one cycle after reset.
  - mode is sampled after that cycle.
- LOOP latency: a word written at edge N is presented with out_valid high after edge N.
  - There is no same-cycle fall-through when the buffer is empty.
- Full buffer: in_ready = 0 even if out_ready = 1 in the same cycle (no write bypass). in_ready rises the cycle after a read.
- Simultaneous read and write with the buffer non-empty and non-full: fill unchanged.
- fill, xfer_count, err_count and err_flag are registered and update one edge after the transfer.
- Reset mid-operation drops buffered data with no further transfers.

## Structure
- Package glip_loopback_pkg: mode encodings MODE_LOOP/GEN/CHECK/IDLE and the 2-bit mode type.
- Sub-module glip_fifo_sync (WIDTH, DEPTH, clk, rst_n, flush): registered-output synchronous FIFO with ready/valid ports and a fill output. LOOP uses it.
- The top level holds mode_q, the FLUSH state, the generator/expected register, the counters and the output muxing.

## Test plan
- Reset:
  - Stimulus: hold rst_n low 3 cycles with mode=LOOP and in_valid=1.
  - Required: in_ready=out_valid=0 through reset +1 cycle; counters 0; fill=0.
- LOOP backpressure:
  - Stimulus: DEPTH=16, out_ready=0, host offers 20 words 0x0100..0x0113.
  - Required: 16 accepted; in_ready=0; fill=16.
  - Then out_ready=1: out_data sequence 0x0100..0x0113 in order; xfer_count=20.
- GEN with wrap:
  - Stimulus: WIDTH=8, out_ready=1 for 300 cycles after FLUSH.
  - Required: out_data 0x00..0xFF, then 0x00..0x2B; xfer_count=300.
- CHECK error:
  - Stimulus: inputs 0,1,2,7,8,9.
  - Required: err_count=1, err_flag=1, xfer_count=6; no further errors after resync.
- Mode change mid-stream:
  - Stimulus: LOOP with fill=5, then switch to CHECK.
  - Required: one FLUSH cycle with both handshakes low; fill=0, counters 0; first CHECK input 0 gives no error.
- Saturation:
  - Stimulus: ERR_WIDTH=2, CHECK, 6 mismatching words.
  - Required: err_count stays 3.
